// File: rtl/correlator_sequencer.sv
// Front-end scheduler for the time-multiplexed correlator array.
// Each accepted I/Q sample word is held for TRATE cycles while the time-slice
// address sweeps. Words are grouped into accumulation blocks of LOOP0 words.
module correlator_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TRATE = 30,
    parameter int unsigned LOOP0 = 8,
    localparam int unsigned TBITS = $clog2(TRATE),
    localparam int unsigned CBITS = $clog2(LOOP0)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             sig_valid_i,
    output logic             sig_ready_o,
    input  logic [WIDTH-1:0] sig_idata_i,
    input  logic [WIDTH-1:0] sig_qdata_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             next_o,
    output logic             emit_o,
    output logic             last_o,
    output logic [TBITS-1:0] taddr_o,
    output logic [WIDTH-1:0] idata_o,
    output logic [WIDTH-1:0] qdata_o,
    output logic             busy_o
);

    localparam logic [TBITS-1:0] TLast = TBITS'(TRATE - 1);
    localparam logic [CBITS-1:0] CLast = CBITS'(LOOP0 - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSlice} state_e;

    state_e           state_q, state_d;
    logic [TBITS-1:0] taddr_q, taddr_d;
    logic [CBITS-1:0] bcnt_q, bcnt_d;
    logic [CBITS-1:0] acc_idx_q, acc_idx_d;
    logic [WIDTH-1:0] cur_idata_q, cur_idata_d;
    logic [WIDTH-1:0] cur_qdata_q, cur_qdata_d;
    logic [WIDTH-1:0] hold_idata_q, hold_idata_d;
    logic [WIDTH-1:0] hold_qdata_q, hold_qdata_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;

    // acc_idx_q is the block index the next accepted word will carry. A nonzero
    // value means the open block still owes words, so those are taken even
    // with enable low; once all LOOP0 words are in, enable alone decides.
    assign sig_ready_o = !reset && !hold_full_q && (enable_i || (acc_idx_q != '0));
    assign accept      = sig_valid_i && sig_ready_o;

    // Next-state: word loading, slice sweep and block counting.
    always_comb begin
        state_d      = state_q;
        taddr_d      = taddr_q;
        bcnt_d       = bcnt_q;
        acc_idx_d    = acc_idx_q;
        cur_idata_d  = cur_idata_q;
        cur_qdata_d  = cur_qdata_q;
        hold_idata_d = hold_idata_q;
        hold_qdata_d = hold_qdata_q;
        hold_full_d  = hold_full_q;

        if (accept) begin
            acc_idx_d = (acc_idx_q == CLast) ? '0 : acc_idx_q + CBITS'(1);
        end

        unique case (state_q)
            StIdle, StWait: begin
                if (accept) begin
                    cur_idata_d = sig_idata_i;
                    cur_qdata_d = sig_qdata_i;
                    taddr_d     = '0;
                    state_d     = StSlice;
                end
            end
            StSlice: begin
                if (taddr_q != TLast) begin
                    taddr_d = taddr_q + TBITS'(1);
                    if (accept) begin
                        hold_idata_d = sig_idata_i;
                        hold_qdata_d = sig_qdata_i;
                        hold_full_d  = 1'b1;
                    end
                end else begin
                    taddr_d = '0;
                    bcnt_d  = (bcnt_q == CLast) ? '0 : bcnt_q + CBITS'(1);
                    if (hold_full_q) begin
                        // Ready is low while the holding register is full,
                        // so no new word can arrive on this edge.
                        cur_idata_d = hold_idata_q;
                        cur_qdata_d = hold_qdata_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Direct load on the wrap edge avoids a bubble.
                        cur_idata_d = sig_idata_i;
                        cur_qdata_d = sig_qdata_i;
                    end else begin
                        state_d = (bcnt_q == CLast) ? StIdle : StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            taddr_q      <= '0;
            bcnt_q       <= '0;
            acc_idx_q    <= '0;
            cur_idata_q  <= '0;
            cur_qdata_q  <= '0;
            hold_idata_q <= '0;
            hold_qdata_q <= '0;
            hold_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            taddr_q      <= taddr_d;
            bcnt_q       <= bcnt_d;
            acc_idx_q    <= acc_idx_d;
            cur_idata_q  <= cur_idata_d;
            cur_qdata_q  <= cur_qdata_d;
            hold_idata_q <= hold_idata_d;
            hold_qdata_q <= hold_qdata_d;
            hold_full_q  <= hold_full_d;
        end
    end

    // Strobes decode directly from registered state; nothing combinational
    // from the inputs reaches them.
    always_comb begin
        valid_o = (state_q == StSlice);
        busy_o  = (state_q != StIdle);
        first_o = valid_o && (bcnt_q == '0);
        emit_o  = valid_o && (bcnt_q == CLast);
        next_o  = valid_o && (taddr_q == '0);
        last_o  = valid_o && (taddr_q == TLast);
        taddr_o = taddr_q;
        idata_o = cur_idata_q;
        qdata_o = cur_qdata_q;
    end

endmodule

// File: tb/tb_correlator_sequencer.sv
// Self-checking bench for correlator_sequencer with TRATE=4, LOOP0=3.
module tb_correlator_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TRATE = 4;
    localparam int unsigned LOOP0 = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable_i = 1'b0;
    logic             sig_valid_i = 1'b0;
    logic [WIDTH-1:0] sig_idata_i = '0;
    logic [WIDTH-1:0] sig_qdata_i = '0;
    logic             sig_ready_o;
    logic             valid_o, first_o, next_o, emit_o, last_o, busy_o;
    logic [1:0]       taddr_o;
    logic [WIDTH-1:0] idata_o, qdata_o;

    correlator_sequencer #(
        .WIDTH(WIDTH),
        .TRATE(TRATE),
        .LOOP0(LOOP0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable_i   (enable_i),
        .sig_valid_i(sig_valid_i),
        .sig_ready_o(sig_ready_o),
        .sig_idata_i(sig_idata_i),
        .sig_qdata_i(sig_qdata_i),
        .valid_o    (valid_o),
        .first_o    (first_o),
        .next_o     (next_o),
        .emit_o     (emit_o),
        .last_o     (last_o),
        .taddr_o    (taddr_o),
        .idata_o    (idata_o),
        .qdata_o    (qdata_o),
        .busy_o     (busy_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] q;
        logic             f;
        logic             e;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   blk_idx  = 0;
    int   n_acc    = 0;
    int   pop_miss = 0;
    int   checks   = 0;
    int   errors   = 0;

    // Advance one cycle: record an accepted word with its expected block role,
    // then on the falling edge pop the scoreboard when a new word appears.
    task automatic tick();
        logic acc;
        #1;
        acc = sig_valid_i && sig_ready_o;
        @(posedge clock);
        if (acc) begin
            sb.push_back({sig_idata_i, sig_qdata_i, (blk_idx == 0), (blk_idx == LOOP0 - 1)});
            blk_idx = (blk_idx == LOOP0 - 1) ? 0 : blk_idx + 1;
            n_acc++;
        end
        @(negedge clock);
        if (valid_o && next_o) begin
            if (sb.size() > 0) cur_exp = sb.pop_front();
            else pop_miss++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable_i    = 1'b0;
        sig_valid_i = 1'b0;
        tick();
        reset   = 1'b0;
        sb.delete();
        blk_idx = 0;
    endtask

    task automatic rand_data();
        sig_idata_i = $urandom;
        sig_qdata_i = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_i = 1'b1; sig_valid_i = 1'b1;
        rand_data();
        tick();
        tick();
        checks++;
        if (sig_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", sig_ready_o);
        end
        checks++;
        if ({valid_o, first_o, next_o, emit_o, last_o, busy_o, taddr_o, idata_o, qdata_o} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs got v%b f%b n%b e%b l%b b%b t%0d i%h q%h want all 0",
                     valid_o, first_o, next_o, emit_o, last_o, busy_o, taddr_o, idata_o, qdata_o);
        end
        sig_valid_i = 1'b0;
        reset = 1'b0;
        sb.delete(); blk_idx = 0;
        #1;
        checks++;
        if ({sig_ready_o, busy_o} !== 2'b10) begin
            errors++; $display("FAIL post_reset_ready_busy got %b%b want 10", sig_ready_o, busy_o);
        end
    endtask

    task automatic test_single();
        logic [3+2*WIDTH:0] got, want;
        do_reset();
        enable_i = 1'b1; sig_valid_i = 1'b1;
        sig_idata_i = 32'hA5A5A5A5; sig_qdata_i = 32'h5A5A5A5A;
        tick();
        sig_valid_i = 1'b0; sig_idata_i = '0; sig_qdata_i = '0;
        for (int k = 0; k < 4; k++) begin
            got  = {valid_o, next_o, first_o, taddr_o, idata_o, qdata_o};
            want = {1'b1, (k == 0), 1'b1, 2'(k), 32'hA5A5A5A5, 32'h5A5A5A5A};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL single_word k=%0d got %h want %h", k, got, want);
            end
            tick();
        end
        checks++;
        if ({valid_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL single_then_wait got v%b b%b want v0 b1", valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, want;
        do_reset();
        enable_i = 1'b1; sig_valid_i = 1'b1;
        rand_data();
        tick();
        for (int c = 0; c < 36; c++) begin
            got  = {valid_o, taddr_o, next_o, last_o, first_o, emit_o, busy_o, sig_ready_o};
            want = {1'b1, 2'(c % 4), (c % 4 == 0), (c % 4 == 3), (c % 12 < 4), (c % 12 >= 8),
                    1'b1, (c % 4 == 0)};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL b2b_strobes c=%0d got %b want %b", c, got, want);
            end
            checks++;
            if ({idata_o, qdata_o, first_o, emit_o} !== cur_exp) begin
                errors++;
                $display("FAIL b2b_data c=%0d got %h/%h f%b e%b want %h/%h f%b e%b", c, idata_o,
                         qdata_o, first_o, emit_o, cur_exp.i, cur_exp.q, cur_exp.f, cur_exp.e);
            end
            rand_data();
            tick();
        end
        checks++;
        if (pop_miss !== 0) begin
            errors++; $display("FAIL b2b_underflow got %0d want 0", pop_miss);
        end
    endtask

    task automatic test_stall();
        logic [7:0] got, want;
        do_reset();
        enable_i = 1'b1; sig_valid_i = 1'b1;
        rand_data();
        tick();
        sig_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            got = {valid_o, first_o, next_o, emit_o, last_o, busy_o, taddr_o};
            if (c < 4) want = {1'b1, 1'b1, (c == 0), 1'b0, (c == 3), 1'b1, 2'(c)};
            else       want = {6'b000001, 2'd0};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL stall c=%0d got %b want %b", c, got, want);
            end
            tick();
        end
        sig_valid_i = 1'b1;
        rand_data();
        tick();
        sig_valid_i = 1'b0;
        checks++;
        if ({valid_o, next_o, first_o, emit_o, busy_o, taddr_o} !== 7'b1100100) begin
            errors++;
            $display("FAIL stall_resume got v%b n%b f%b e%b b%b t%0d want v1 n1 f0 e0 b1 t0",
                     valid_o, next_o, first_o, emit_o, busy_o, taddr_o);
        end
        checks++;
        if ({idata_o, qdata_o, first_o, emit_o} !== cur_exp) begin
            errors++; $display("FAIL stall_data got %h/%h want %h/%h", idata_o, qdata_o,
                               cur_exp.i, cur_exp.q);
        end
    endtask

    task automatic test_enable_drop();
        int n0;
        int emit_cycles = 0;
        do_reset();
        n0 = n_acc;
        enable_i = 1'b1; sig_valid_i = 1'b1;
        rand_data();
        tick();
        enable_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (valid_o) begin
                checks++;
                if ({idata_o, qdata_o, first_o, emit_o} !== cur_exp) begin
                    errors++; $display("FAIL drop_data c=%0d got %h/%h f%b e%b want f%b e%b", c,
                                       idata_o, qdata_o, first_o, emit_o, cur_exp.f, cur_exp.e);
                end
            end
            if (emit_o) emit_cycles++;
            rand_data();
            tick();
        end
        checks++;
        if (n_acc - n0 !== 3) begin
            errors++; $display("FAIL drop_accepted got %0d want 3", n_acc - n0);
        end
        checks++;
        if (emit_cycles !== 4) begin
            errors++; $display("FAIL drop_emit_cycles got %0d want 4", emit_cycles);
        end
        checks++;
        if ({sig_ready_o, busy_o, valid_o} !== 3'b000) begin
            errors++; $display("FAIL drop_idle got r%b b%b v%b want 000", sig_ready_o, busy_o,
                               valid_o);
        end
        sig_valid_i = 1'b0;
        enable_i = 1'b1;
        #1;
        checks++;
        if (sig_ready_o !== 1'b1) begin
            errors++; $display("FAIL drop_reenable_ready got %b want 1", sig_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable_i = 1'b1; sig_valid_i = 1'b1;
        rand_data();
        tick();
        for (int c = 0; c < 6; c++) begin
            rand_data();
            tick();
        end
        checks++;
        if ({valid_o, first_o, emit_o, taddr_o} !== 5'b10010) begin
            errors++; $display("FAIL mid_position got v%b f%b e%b t%0d want v1 f0 e0 t2",
                               valid_o, first_o, emit_o, taddr_o);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({sig_ready_o, valid_o, first_o, next_o, emit_o, last_o, busy_o, taddr_o, idata_o,
             qdata_o} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got r%b v%b b%b t%0d i%h want all 0",
                               sig_ready_o, valid_o, busy_o, taddr_o, idata_o);
        end
        reset = 1'b0;
        sb.delete(); blk_idx = 0;
        rand_data();
        tick();
        sig_valid_i = 1'b0;
        checks++;
        if ({valid_o, first_o, next_o, taddr_o} !== 5'b11100) begin
            errors++; $display("FAIL mid_restart got v%b f%b n%b t%0d want v1 f1 n1 t0",
                               valid_o, first_o, next_o, taddr_o);
        end
        checks++;
        if ({idata_o, qdata_o, first_o, emit_o} !== cur_exp) begin
            errors++; $display("FAIL mid_restart_data got %h/%h want %h/%h", idata_o, qdata_o,
                               cur_exp.i, cur_exp.q);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
